// File: rtl/vga_timing_gen.sv
// -----------------------------------------------------------------------------
// vga_timing_gen
//
// Purpose:
//   Raster timing generator for a VGA-style display. A clock divider produces
//   one pixel tick every CLK_DIV enabled clk cycles. On each tick the module
//   registers the sync, blanking and coordinate outputs decoded from the
//   current raster position (hc, vc), then advances the position. Outputs
//   therefore lag the counters by one tick, and pix_en marks the clk in which
//   the new values appear.
//
// Optional feature:
//   VGA_FRAME_CNT_EN - when defined, frame_cnt counts completed frames
//                      (modulo 256). When undefined, no frame-counter flops
//                      are built and frame_cnt is tied to 0.
//
// Ports:
//   clk          in   system clock
//   rst          in   asynchronous, active-high reset
//   en           in   run enable; timing freezes while low
//   pix_en       out  one-clk strobe, high in the clk the outputs update
//   hsync        out  horizontal sync, at HS_POL level while asserted
//   vsync        out  vertical sync, at VS_POL level while asserted
//   activevideo  out  high while the current pixel is visible
//   x_px         out  visible column, 0 outside the active region
//   y_px         out  visible row, 0 outside the active region
//   line_start   out  high for the tick of pixel hc=0
//   frame_start  out  high for the tick of pixel hc=0, vc=0
//   frame_cnt    out  completed frames modulo 256
// -----------------------------------------------------------------------------
module vga_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0,
    parameter int CLK_DIV  = 1,
    parameter int CNT_W    = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    output logic             pix_en,
    output logic             hsync,
    output logic             vsync,
    output logic             activevideo,
    output logic [CNT_W-1:0] x_px,
    output logic [CNT_W-1:0] y_px,
    output logic             line_start,
    output logic             frame_start,
    output logic [7:0]       frame_cnt
);

    // -------------------------------------------------------------------------
    // Derived timing constants, sized to the counters they are compared with
    // -------------------------------------------------------------------------
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_VIS    = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_VIS    = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] HS_START = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] VS_START = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [DIV_W-1:0] div_q;
    logic [CNT_W-1:0] hc;
    logic [CNT_W-1:0] vc;

    // Held copies of the start flags; the ports gate them with pix_en so they
    // can only be seen during an update clk, while the flops themselves keep
    // their value across disabled periods like every other output.
    logic             line_start_q;
    logic             frame_start_q;

    // -------------------------------------------------------------------------
    // Tick generation and position decode
    // -------------------------------------------------------------------------
    logic tick;
    logic line_end;
    logic frame_end;
    logic h_vis;
    logic v_vis;
    logic hs_on;
    logic vs_on;

    // NOTE: every signal written in an always_comb gets a value on every path
    // (here unconditionally) so no latch is inferred.
    always_comb begin
        tick      = en && (div_q == DIV_LAST);
        line_end  = (hc == H_LAST);
        frame_end = line_end && (vc == V_LAST);
        h_vis     = (hc < H_VIS);
        v_vis     = (vc < V_VIS);
        hs_on     = (hc >= HS_START) && (hc < HS_END);
        vs_on     = (vc >= VS_START) && (vc < VS_END);
    end

    // -------------------------------------------------------------------------
    // Divider and raster counters
    // -------------------------------------------------------------------------
    // NOTE: state is updated with non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q <= '0;
            hc    <= '0;
            vc    <= '0;
        end else if (en) begin
            if (tick) begin
                div_q <= '0;
                if (line_end) begin
                    hc <= '0;
                    vc <= frame_end ? '0 : vc + 1'b1;
                end else begin
                    hc <= hc + 1'b1;
                end
            end else begin
                div_q <= div_q + 1'b1;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Registered outputs: loaded from the decode of (hc, vc) on each tick and
    // held otherwise. pix_en follows tick, so it drops whenever en is low.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pix_en        <= 1'b0;
            hsync         <= ~HS_POL;
            vsync         <= ~VS_POL;
            activevideo   <= 1'b0;
            x_px          <= '0;
            y_px          <= '0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            pix_en <= tick;
            if (tick) begin
                hsync         <= hs_on ? HS_POL : ~HS_POL;
                vsync         <= vs_on ? VS_POL : ~VS_POL;
                activevideo   <= h_vis && v_vis;
                x_px          <= (h_vis && v_vis) ? hc : '0;
                y_px          <= (h_vis && v_vis) ? vc : '0;
                line_start_q  <= (hc == '0);
                frame_start_q <= (hc == '0) && (vc == '0);
            end
        end
    end

    assign line_start  = line_start_q  & pix_en;
    assign frame_start = frame_start_q & pix_en;

    // -------------------------------------------------------------------------
    // Completed-frame counter. It advances on the tick that consumes the last
    // pixel of the frame, so it already reads N while pixel (0,0) of frame N
    // is being presented. The 8-bit add wraps 255 -> 0 naturally.
    // -------------------------------------------------------------------------
`ifdef VGA_FRAME_CNT_EN
    logic [7:0] frame_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_cnt_q <= '0;
        end else if (tick && frame_end) begin
            frame_cnt_q <= frame_cnt_q + 8'd1;
        end
    end

    assign frame_cnt = frame_cnt_q;
`else
    assign frame_cnt = 8'd0;
`endif

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 H_ACTIVE, 640, visible pixels per line.
REQ-002 H_FP, 16, horizontal front porch, in pixels.
REQ-003 H_SYNC, 96, hsync pulse width, in pixels.
REQ-004 H_BP, 48, horizontal back porch, in pixels.
REQ-005 V_ACTIVE, 480, visible lines per frame.
REQ-006 V_FP, 10, vertical front porch, in lines.
REQ-007 V_SYNC, 2, vsync pulse width, in lines.
REQ-008 V_BP, 33, vertical back porch, in lines.
REQ-009 HS_POL, 0, asserted hsync level (0 = active-low).
REQ-010 VS_POL, 0, asserted vsync level (0 = active-low).
REQ-011 CLK_DIV, 1, clk cycles per pixel tick (>=1).
REQ-012 CNT_W, 10, width of the counters and of x_px/y_px; must hold H_TOTAL-1 and V_TOTAL-1.
REQ-013 clk  in  1  system clock.
REQ-014 rst  in  1  asynchronous, active-high reset.
REQ-015 en  in  1  run enable; when low, timing freezes.
REQ-016 pix_en  out  1  one-clk strobe; high in the cycle the other outputs update.
REQ-017 hsync  out  1  horizontal sync, at HS_POL level while asserted.
REQ-018 vsync  out  1  vertical sync, at VS_POL level while asserted.
REQ-019 activevideo  out  1  high while the current pixel is visible.
REQ-020 x_px  out  CNT_W  visible column; 0 outside the active region.
REQ-021 y_px  out  CNT_W  visible row; 0 outside the active region.
REQ-022 line_start  out  1  high for the tick of pixel hc=0.
REQ-023 frame_start  out  1  high for the tick of pixel hc=0, vc=0.
REQ-024 frame_cnt  out  8  count of completed frames, modulo 256.

Function
REQ-025 H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP.
REQ-026 Divider counts 0..CLK_DIV-1 while en=1. A tick occurs when the divider is at CLK_DIV-1, so CLK_DIV=1 gives a tick every enabled clk.
REQ-027 On each tick, all outputs register values decoded from the current (hc,vc), then hc advances. Output latency is one tick, and pix_en is asserted in that same clk.
REQ-028 Line order: active hc 0..H_ACTIVE-1, then front porch, then sync, then back porch. Vertical order is the same, counted in lines.
REQ-029 hsync is asserted for H_ACTIVE+H_FP <= hc < H_ACTIVE+H_FP+H_SYNC. vsync is asserted for V_ACTIVE+V_FP <= vc < V_ACTIVE+V_FP+V_SYNC, for whole lines.
REQ-030 activevideo = (hc<H_ACTIVE && vc<V_ACTIVE). x_px=hc and y_px=vc when active, otherwise both are 0.
REQ-031 At hc=H_TOTAL-1, hc wraps to 0 and vc increments. At vc=V_TOTAL-1, vc also wraps to 0 and frame_cnt increments, wrapping at 255 to 0.
REQ-032 While en=0: divider, hc, vc, frame_cnt and all registered outputs hold, and pix_en=0. Operation resumes from the held point when en returns to 1.
REQ-033 line_start and frame_start are high only for clks where pix_en=1.

Reset
REQ-034 rst=1 immediately clears, without a clk edge: divider, hc, vc, frame_cnt, x_px, y_px, activevideo, pix_en, line_start and frame_start. hsync is driven to ~HS_POL and vsync to ~VS_POL.
REQ-035 After rst falls, the first tick outputs pixel (0,0) with activevideo=1, line_start=1 and frame_start=1. Reset mid-frame restarts at (0,0).

Configuration
REQ-036 VGA_FRAME_CNT_EN defined: frame_cnt counts as in REQ-031. Undefined: no frame-counter flops are built and frame_cnt is tied to 0.

Verification
REQ-037 Defaults, reset, one line of 800 ticks -> x_px runs 0..639 with activevideo=1, hsync low for ticks 656..751 (96 ticks), and line_start exactly once.
REQ-038 Defaults, 420000 ticks -> one frame_start, 307200 active ticks, and vsync low throughout lines 490..491 (1600 ticks).
REQ-039 CLK_DIV=3 -> pix_en asserted every 3rd clk, and outputs change only in clks with pix_en=1.
REQ-040 en=0 for 50 clks after x_px=100 -> x_px holds 100 and pix_en=0; after en=1, the next tick gives x_px=101.
REQ-041 rst pulsed mid-frame between clk edges -> all outputs take reset values immediately, and the first tick after release gives x_px=0, y_px=0, frame_start=1.
REQ-042 HS_POL=1, VGA_FRAME_CNT_EN defined, 3 frames run -> hsync high only during sync and frame_cnt=3. Rebuilt without the macro -> frame_cnt stays 0.
